// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - shared states, error codes and iNES constants for the flash ROM loader
package flash_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_RD,
    ST_CHECK,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0]  ERR_NONE   = 2'd0;
  localparam logic [1:0]  ERR_MAGIC  = 2'd1;
  localparam logic [1:0]  ERR_SIZE   = 2'd2;

  localparam logic [31:0] INES_MAGIC = 32'h4E45531A;
  localparam int          HDR_LEN    = 16;
  localparam logic [23:0] PRG_UNIT   = 24'd16384;
  localparam logic [23:0] CHR_UNIT   = 24'd8192;

endpackage

// File: rtl/ines_header_capture.sv
// rtl/ines_header_capture.sv - stores iNES header bytes 0-7, checks the magic, registers payload size
module ines_header_capture
  import flash_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_idx_i,
  input  logic [7:0]  wr_data_i,
  output logic        magic_ok_o,
  output logic [23:0] total_o,
  output logic [7:0]  prg_banks_o,
  output logic [7:0]  chr_banks_o,
  output logic [15:0] rom_flags_o
);

  logic [7:0]  hdr_q [8];
  logic [23:0] total_q;

  // Size is re-registered every cycle; bytes 4/5 land long before the last header byte.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < 8; i++) hdr_q[i] <= 8'd0;
      total_q <= 24'd0;
    end else begin
      if (wr_en_i && !wr_idx_i[3]) hdr_q[wr_idx_i[2:0]] <= wr_data_i;
      total_q <= 24'(hdr_q[4]) * PRG_UNIT + 24'(hdr_q[5]) * CHR_UNIT;
    end
  end

  assign magic_ok_o  = ({hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3]} == INES_MAGIC);
  assign total_o     = total_q;
  assign prg_banks_o = hdr_q[4];
  assign chr_banks_o = hdr_q[5];
  assign rom_flags_o = {hdr_q[7], hdr_q[6]};

endmodule

// File: rtl/flash_rom_loader.sv
// rtl/flash_rom_loader.sv - boot loader copying an iNES image from SPI flash into cartridge memory
// Optional payload checksum output when LOADER_CHECKSUM_EN is defined.
module flash_rom_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter logic [23:0] MAX_BYTES  = 24'h080000,
  parameter int          MEM_AW     = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              flash_valid,
  output logic [23:0]       flash_addr,
  input  logic              flash_ready,
  input  logic [7:0]        flash_rdata,
  output logic              mem_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [15:0]       rom_flags
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [23:0]       n_q, n_d;
  logic              fvalid_q, fvalid_d;
  logic [23:0]       faddr_q, faddr_d;
  logic              mwr_q, mwr_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
  logic [1:0]        err_q, err_d;
  logic              hdr_wr, hdr_clear;
  logic              magic_ok;
  logic [23:0]       total;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  ines_header_capture u_hdr (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (hdr_clear),
    .wr_en_i     (hdr_wr),
    .wr_idx_i    (idx_q),
    .wr_data_i   (flash_rdata),
    .magic_ok_o  (magic_ok),
    .total_o     (total),
    .prg_banks_o (prg_banks),
    .chr_banks_o (chr_banks),
    .rom_flags_o (rom_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      n_q      <= 24'd0;
      fvalid_q <= 1'b0;
      faddr_q  <= 24'd0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= 8'd0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      fvalid_q <= fvalid_d;
      faddr_q  <= faddr_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      err_q    <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) csum_q <= 16'd0;
    else       csum_q <= csum_d;
  end
  assign checksum = csum_q;
`endif

  // A flash request is raised only from a low cycle, so valid always idles >=1 cycle after ready.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    fvalid_d  = fvalid_q;
    faddr_d   = faddr_q;
    mwr_d     = mwr_q;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    err_d     = err_q;
    hdr_wr    = 1'b0;
    hdr_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d   = ST_HDR_RD;
          idx_d     = 4'd0;
          n_d       = 24'd0;
          err_d     = ERR_NONE;
          hdr_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = 16'd0;
`endif
        end
      end
      ST_HDR_RD: begin
        if (fvalid_q) begin
          if (flash_ready) begin
            fvalid_d = 1'b0;
            hdr_wr   = 1'b1;
            if (idx_q == 4'(HDR_LEN - 1)) state_d = ST_CHECK;
            else                          idx_d   = idx_q + 4'd1;
          end
        end else begin
          fvalid_d = 1'b1;
          faddr_d  = FLASH_BASE + {20'd0, idx_q};
        end
      end
      ST_CHECK: begin
        if (!magic_ok) begin
          state_d = ST_ERR;
          err_d   = ERR_MAGIC;
        end else if (total == 24'd0 || total > MAX_BYTES) begin
          state_d = ST_ERR;
          err_d   = ERR_SIZE;
        end else begin
          state_d = ST_DATA_RD;
        end
      end
      ST_DATA_RD: begin
        if (fvalid_q) begin
          if (flash_ready) begin
            fvalid_d = 1'b0;
            mwr_d    = 1'b1;
            maddr_d  = n_q[MEM_AW-1:0];
            mdata_d  = flash_rdata;
            state_d  = ST_DATA_WR;
          end
        end else begin
          fvalid_d = 1'b1;
          faddr_d  = FLASH_BASE + 24'(HDR_LEN) + n_q;
        end
      end
      ST_DATA_WR: begin
        if (mem_ack && mwr_q) begin
          mwr_d   = 1'b0;
          n_d     = n_q + 24'd1;
          state_d = (n_q + 24'd1 == total) ? ST_DONE : ST_DATA_RD;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + {8'd0, mdata_q};
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flash_valid = fvalid_q;
  assign flash_addr  = faddr_q;
  assign mem_wr      = mwr_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = mdata_q;
  assign err         = err_q;
  assign done        = (state_q == ST_DONE);
  assign busy        = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

endmodule

// File: tb/tb_flash_rom_loader.sv
// tb/tb_flash_rom_loader.sv - randomized scoreboard bench for flash_rom_loader
module tb_flash_rom_loader;

  localparam logic [23:0] FLASH_BASE = 24'h100000;
  localparam int          MAX_BYTES  = 'h80000;
  localparam int          IMG_SZ     = 65536;

  logic        clk = 1'b0;
  logic        reset, start, flash_ready, mem_ack;
  logic [7:0]  flash_rdata;
  logic        flash_valid, mem_wr, busy, done;
  logic [23:0] flash_addr;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, prg_banks, chr_banks;
  logic [1:0]  err;
  logic [15:0] rom_flags;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  flash_rom_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .flash_valid(flash_valid), .flash_addr(flash_addr),
    .flash_ready(flash_ready), .flash_rdata(flash_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .rom_flags(rom_flags)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] img [IMG_SZ];
  wr_t        exp_q [$];
  int         f_max = 0, m_max = 0;
  int         flash_reads = 0, wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Flash reader and memory port models plus the scoreboard monitor.
  initial begin
    bit          f_pend, m_pend, last_rdy;
    int          f_lat, m_lat, idx;
    logic [23:0] f_addr;
    logic [21:0] m_addr;
    logic [7:0]  m_data;
    wr_t         e;
    f_pend = 0; m_pend = 0; last_rdy = 0; f_lat = 0; m_lat = 0;
    f_addr = '0; m_addr = '0; m_data = '0;
    flash_ready = 1'b0; mem_ack = 1'b0; flash_rdata = 8'd0;
    forever begin
      @(negedge clk);
      flash_ready = 1'b0;
      mem_ack     = 1'b0;
      flash_rdata = 8'($urandom);
      if (reset) begin
        f_pend = 0; m_pend = 0; last_rdy = 0;
      end else begin
        if (last_rdy) check("flash_gap", 32'(flash_valid), 32'd0);
        last_rdy = 0;
        if (flash_valid) begin
          check("req_overlap", 32'(mem_wr), 32'd0);
          if (!f_pend) begin
            f_pend = 1; f_addr = flash_addr; f_lat = $urandom_range(0, f_max);
          end else begin
            check("flash_addr_stable", 32'(flash_addr), 32'(f_addr));
          end
          if (f_lat == 0) begin
            idx = int'(flash_addr) - int'(FLASH_BASE);
            if (idx < 0 || idx >= IMG_SZ) begin
              checks++; errors++;
              $display("FAIL flash_addr_range: got 0x%0h outside image", flash_addr);
            end else begin
              flash_rdata = img[idx];
            end
            flash_ready = 1'b1; f_pend = 0; last_rdy = 1; flash_reads++;
          end else begin
            f_lat--;
          end
        end
        if (mem_wr) begin
          if (!m_pend) begin
            m_pend = 1; m_addr = mem_addr; m_data = mem_wdata; m_lat = $urandom_range(0, m_max);
          end else begin
            check("mem_addr_stable", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata_stable", 32'(mem_wdata), 32'(m_data));
          end
          if (m_lat == 0) begin
            mem_ack = 1'b1; m_pend = 0; wr_count++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
              e = exp_q.pop_front();
              check("mem_addr", 32'(mem_addr), 32'(e.addr));
              check("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end
          end else begin
            m_lat--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;  // stray ack with no write pending must be ignored
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] prg, input logic [7:0] chr, input bit bad_magic,
                          input int fmax, input int mmax, input int abort_at, input bit busy_start);
    int         total, nexp, fill, t;
    logic [1:0] exp_err;
    logic [15:0] esum;
    total = int'(prg) * 16384 + int'(chr) * 8192;
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = bad_magic ? 8'h1B : 8'h1A;
    img[4] = prg; img[5] = chr;
    for (int i = 6; i < 16; i++) img[i] = 8'($urandom);
    if (bad_magic)                              exp_err = 2'd1;
    else if (total == 0 || total > MAX_BYTES)   exp_err = 2'd2;
    else                                        exp_err = 2'd0;
    fill = (total < IMG_SZ - 16) ? total : IMG_SZ - 16;
    for (int i = 0; i < fill; i++) img[16 + i] = 8'($urandom);
    nexp = (exp_err != 0) ? 0 : (abort_at > 0 ? abort_at : total);
    esum = 16'd0;
    exp_q.delete();
    for (int n = 0; n < nexp; n++) begin
      exp_q.push_back('{addr: 22'(n), data: img[16 + n]});
      esum = esum + 16'(img[16 + n]);
    end
    flash_reads = 0; wr_count = 0; f_max = fmax; m_max = mmax;

    @(posedge clk); #1;
    pulse_start();
    t = 0;
    if (abort_at > 0) begin
      while (wr_count < abort_at && t < 20000) begin @(posedge clk); #1; t++; end
      check("abort_wait_timeout", 32'(t >= 20000), 32'd0);
      check("busy_mid_load", 32'(busy), 32'd1);
      check("err_mid_load", 32'(err), 32'd0);
      check("prg_banks", 32'(prg_banks), 32'(prg));
      check("chr_banks", 32'(chr_banks), 32'(chr));
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort_flash_valid", 32'(flash_valid), 32'd0);
      check("abort_mem_wr", 32'(mem_wr), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done_err", 32'({done, err}), 32'd0);
      check("abort_write_count", 32'(wr_count), 32'(abort_at));
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
    end else begin
      if (busy_start) begin
        while (wr_count < 300 && t < 20000) begin @(posedge clk); #1; t++; end
        check("busy_start_wait_timeout", 32'(t >= 20000), 32'd0);
        pulse_start();
      end
      t = 0;
      while (!done && err == 2'd0 && t < 60000) begin @(posedge clk); #1; t++; end
      check("load_timeout", 32'(t >= 60000), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done", 32'(done), 32'(exp_err == 2'd0));
      check("err", 32'(err), 32'(exp_err));
      check("busy_end", 32'(busy), 32'd0);
      check("prg_banks", 32'(prg_banks), 32'(prg));
      check("chr_banks", 32'(chr_banks), 32'(chr));
      check("rom_flags", 32'(rom_flags), 32'({img[7], img[6]}));
      check("write_count", 32'(wr_count), 32'(nexp));
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      check("flash_reads", 32'(flash_reads), 32'(16 + nexp));
`ifdef LOADER_CHECKSUM_EN
      if (exp_err == 2'd0) check("checksum", 32'(checksum), 32'(esum));
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flash", 32'({flash_valid, flash_addr}), 32'd0);
    check("rst_mem", 32'({mem_wr, mem_addr, mem_wdata}), 32'd0);
    check("rst_status", 32'({busy, done, err}), 32'd0);
    check("rst_header", 32'({prg_banks, chr_banks, rom_flags}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_load(8'h00, 8'h01, 1'b0, 1, 1, 0, 1'b1);    // full 8 KiB load, start ignored while busy
    run_load(8'h02, 8'h01, 1'b1, 3, 3, 0, 1'b0);    // bad magic
    run_load(8'h00, 8'h00, 1'b0, 2, 2, 0, 1'b0);    // zero payload
    run_load(8'h21, 8'h00, 1'b0, 2, 2, 0, 1'b0);    // payload above the limit
    run_load(8'h02, 8'h01, 1'b0, 5, 20, 100, 1'b0); // reset at n=100, slow ack
    run_load(8'h02, 8'h01, 1'b0, 5, 20, 150, 1'b0); // reload restarts at n=0
    run_load(8'h20, 8'h00, 1'b0, 1, 3, 40, 1'b0);   // payload exactly at the limit is accepted

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
